ffo_seq_scan: RTL and testbench

//   Parametrised sequential find-first-one engine: scans an N-bit operand CHUNK bits per clock,

---
 rtl/ffo_seq_scan.sv | 117 +++++++++++
 tb/tb_ffo_seq_scan.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ffo_seq_scan.sv
// Sequential find-first-one: scans an N-bit operand CHUNK bits per clock from either end,
// with find-next to enumerate successive set bits without reloading.
module ffo_seq_scan #(
  parameter int N     = 32,
  parameter int CHUNK = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 dir,
  input  logic [N-1:0]         b,
  input  logic                 next,
  output logic                 ready,
  output logic                 found,
  output logic [$clog2(N)-1:0] p,
  output logic                 done
);

  localparam int NCH = N / CHUNK;
  localparam int PW  = $clog2(N);
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t         state_q;
  logic [N-1:0]   w_q;
  logic           dir_q;
  logic [CW-1:0]  c_q;
  logic [PW-1:0]  lidx_q;
  logic           ready_q, found_q, done_q;
  logic [PW-1:0]  p_q;

  logic [N-1:0]     b_rev, clr_mask;
  logic [CHUNK-1:0] chunk_bits;
  logic             hit;
  int unsigned      hit_pos;
  logic [PW-1:0]    lidx_d, pidx_d;
  logic [CW-1:0]    c_next_d;

  assign ready = ready_q;
  assign found = found_q;
  assign p     = p_q;
  assign done  = done_q;

  // The working copy is stored bit-reversed for dir=1, so the scan always runs upward in
  // "logical" index space; pidx_d maps the logical index back to the operand index.
  always_comb begin
    b_rev      = {<<{b}};
    clr_mask   = '0;
    clr_mask[lidx_q] = 1'b1;
    chunk_bits = CHUNK'(w_q >> (32'(c_q) * CHUNK));
    hit        = 1'b0;
    hit_pos    = 0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (chunk_bits[i] && !hit) begin
        hit     = 1'b1;
        hit_pos = i;
      end
    end
    lidx_d   = PW'(32'(c_q) * CHUNK + hit_pos);
    pidx_d   = dir_q ? (PW'(N - 1) - lidx_d) : lidx_d;
    c_next_d = CW'(32'(lidx_q) / CHUNK);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      dir_q   <= 1'b0;
      c_q     <= '0;
      lidx_q  <= '0;
      ready_q <= 1'b1;
      found_q <= 1'b0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            w_q     <= dir ? b_rev : b;
            dir_q   <= dir;
            c_q     <= '0;
            ready_q <= 1'b0;
            state_q <= SCAN;
          end else if (next && found_q) begin
            // Chunks before the one holding the last hit are already known to be zero.
            w_q     <= w_q & ~clr_mask;
            c_q     <= c_next_d;
            ready_q <= 1'b0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            lidx_q  <= lidx_d;
            p_q     <= pidx_d;
            found_q <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (c_q == CW'(NCH - 1)) begin
            found_q <= 1'b0;
            p_q     <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            c_q <= c_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ffo_seq_scan.sv
// Bench for ffo_seq_scan: three instances (CHUNK = 1, 4, 32) share stimulus and are checked
// against a set-of-remaining-bits model for result, latency, ready and done.
module tb_ffo_seq_scan;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] st;
  logic       next, dir;
  logic [31:0] b;
  logic [2:0] rdy, fnd, dn;
  logic [2:0][4:0] pp;

  always #5 clock = ~clock;

  ffo_seq_scan #(.N(32), .CHUNK(1)) u_c1 (
    .clock(clock), .reset_n(reset_n), .start(st[0]), .dir(dir), .b(b), .next(next),
    .ready(rdy[0]), .found(fnd[0]), .p(pp[0]), .done(dn[0]));
  ffo_seq_scan #(.N(32), .CHUNK(4)) u_c4 (
    .clock(clock), .reset_n(reset_n), .start(st[1]), .dir(dir), .b(b), .next(next),
    .ready(rdy[1]), .found(fnd[1]), .p(pp[1]), .done(dn[1]));
  ffo_seq_scan #(.N(32), .CHUNK(32)) u_c32 (
    .clock(clock), .reset_n(reset_n), .start(st[2]), .dir(dir), .b(b), .next(next),
    .ready(rdy[2]), .found(fnd[2]), .p(pp[2]), .done(dn[2]));

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // model state
  logic [31:0] mw        = '0;
  logic        mdir      = 1'b0;
  logic        exp_found = 1'b0;
  logic [4:0]  exp_p     = '0;
  int          exp_lat[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int chunk_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 32);
  endfunction

  function automatic int rel(input int idx, input logic d);
    return d ? (31 - idx) : idx;
  endfunction

  function automatic int first_bit(input logic [31:0] v, input logic d);
    if (!d) begin
      for (int i = 0; i < 32; i++) if (v[i]) return i;
    end else begin
      for (int i = 31; i >= 0; i--) if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_apply(input bit is_start, input logic [31:0] bv, input logic dv);
    int s[3];
    int fb;
    if (is_start) begin
      mw = bv;
      mdir = dv;
      for (int i = 0; i < 3; i++) s[i] = 0;
    end else begin
      for (int i = 0; i < 3; i++) s[i] = rel(int'(exp_p), mdir) / chunk_of(i);
      mw[exp_p] = 1'b0;
    end
    fb = first_bit(mw, mdir);
    for (int i = 0; i < 3; i++)
      exp_lat[i] = (fb >= 0) ? (rel(fb, mdir) / chunk_of(i) - s[i] + 1)
                             : (32 / chunk_of(i) - s[i]);
    exp_found = (fb >= 0);
    exp_p     = (fb >= 0) ? 5'(fb) : 5'd0;
  endtask

  // Result must hold whenever an instance reports ready.
  always @(negedge clock) begin
    if (chk_en && reset_n === 1'b1) begin
      for (int i = 0; i < 3; i++) begin
        if (rdy[i]) begin
          check("hold_found", 32'(fnd[i]), 32'(exp_found));
          check("hold_p", 32'(pp[i]), 32'(exp_p));
        end
      end
    end
  end

  task automatic do_op(input bit is_start, input bit with_next, input logic [31:0] bv,
                       input logic dv, input bit intrude, input logic [31:0] ib);
    int maxl;
    @(negedge clock);
    st   = is_start ? 3'b111 : 3'b000;
    next = !is_start || with_next;
    if (is_start) begin
      b   = bv;
      dir = dv;
    end
    @(posedge clock);
    model_apply(is_start, bv, dv);
    #1;
    st   = '0;
    next = 1'b0;
    maxl = 0;
    for (int i = 0; i < 3; i++) if (exp_lat[i] > maxl) maxl = exp_lat[i];
    for (int cyc = 1; cyc <= maxl; cyc++) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) begin
        check("ready_timing", 32'(rdy[i]), 32'(cyc >= exp_lat[i]));
        check("done_timing", 32'(dn[i]), 32'(cyc == exp_lat[i]));
      end
      if (intrude && cyc == 1) begin
        for (int i = 0; i < 3; i++) st[i] = (exp_lat[i] > 2);
        b = ib;
      end else if (intrude && cyc == 2) begin
        st = '0;
      end
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("done_single", 32'(dn[i]), 32'd0);
      check("ready_after", 32'(rdy[i]), 32'd1);
    end
  endtask

  task automatic next_ignored();
    @(negedge clock);
    next = 1'b1;
    @(posedge clock);
    #1;
    next = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ign_next_ready", 32'(rdy[i]), 32'd1);
      check("ign_next_done", 32'(dn[i]), 32'd0);
      check("ign_next_found", 32'(fnd[i]), 32'd0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_ready"}, 32'(rdy[i]), 32'd1);
      check({tag, "_found"}, 32'(fnd[i]), 32'd0);
      check({tag, "_p"}, 32'(pp[i]), 32'd0);
      check({tag, "_done"}, 32'(dn[i]), 32'd0);
    end
  endtask

  initial begin
    logic [4:0] enum_exp[3];
    logic [31:0] rb;
    logic rd;
    enum_exp[0] = 5'd2; enum_exp[1] = 5'd29; enum_exp[2] = 5'd31;
    reset_n = 1'b0; st = '0; next = 1'b0; dir = 1'b0; b = '0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_vals("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_reset_vals("release");
    chk_en = 1'b1;

    do_op(1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, '0);
    check("t2_found", 32'(fnd[1]), 32'd1);
    check("t2_p", 32'(pp[1]), 32'd8);
    check("t2_lat", exp_lat[1], 32'd3);

    do_op(1'b1, 1'b0, 32'h8000_0001, 1'b1, 1'b0, '0);
    check("t3_p31", 32'(pp[1]), 32'd31);
    check("t3_lat1", exp_lat[1], 32'd1);
    do_op(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    check("t3_p0", 32'(pp[1]), 32'd0);
    check("t3_found0", 32'(fnd[1]), 32'd1);
    check("t3_lat8", exp_lat[1], 32'd8);
    do_op(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    check("t3_exhaust", 32'(fnd[1]), 32'd0);

    do_op(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, '0);
    check("t4_found", 32'(fnd[1]), 32'd0);
    check("t4_lat", exp_lat[1], 32'd8);
    next_ignored();

    do_op(1'b1, 1'b0, 32'hA000_0005, 1'b0, 1'b0, '0);
    check("t5_p0", 32'(pp[1]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      do_op(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      check("t5_seq", 32'(pp[1]), 32'(enum_exp[k]));
    end
    do_op(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    check("t5_end", 32'(fnd[1]), 32'd0);

    do_op(1'b1, 1'b0, 32'h0000_1000, 1'b0, 1'b1, 32'h0000_0001);
    check("busy_start_ignored", 32'(pp[1]), 32'd12);
    do_op(1'b1, 1'b1, 32'h0000_0040, 1'b1, 1'b0, '0);
    check("start_beats_next", 32'(pp[1]), 32'd6);

    for (int n = 0; n < 1000; n++) begin
      rb = $urandom & $urandom & $urandom;
      if (n % 97 == 0) rb = '0;
      if (n % 89 == 0) rb = '1;
      rd = 1'($urandom_range(0, 1));
      do_op(1'b1, 1'b0, rb, rd, 1'b0, '0);
      if (exp_found) do_op(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      else next_ignored();
    end

    @(negedge clock);
    st = 3'b111; b = 32'h8000_0000; dir = 1'b0;
    @(posedge clock);
    model_apply(1'b1, 32'h8000_0000, 1'b0);
    #1;
    st = '0;
    repeat (3) @(posedge clock);
    #2;
    check("mid_scan_busy", 32'(rdy[1]), 32'd0);
    reset_n   = 1'b0;
    exp_found = 1'b0;
    exp_p     = '0;
    #1;
    check_reset_vals("abort");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_reset_vals("post_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
